// File: rtl/bus_arbiter.sv
// Two-master / three-slave bus arbiter: fixed-priority or round-robin ownership with a hold limit.
// All outputs are registered; slave select is decoded from the owner's address each owned cycle.
module bus_arbiter #(
  parameter int ROUND_ROBIN = 0,
  parameter int MAX_HOLD    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m1_request,
  input  logic        m2_request,
  input  logic [13:0] m1_addr,
  input  logic [13:0] m2_addr,
  output logic        m1_grant,
  output logic        m2_grant,
  output logic        bus_busy,
  output logic        mux_sel,
  output logic [2:0]  slave_sel,
  output logic        addr_error,
  output logic        timeout
);

  typedef enum logic [1:0] {IDLE, M1_OWN, M2_OWN, TURN} state_t;

  localparam logic [7:0] HOLD_MAX  = 8'(MAX_HOLD);
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic       last_q, last_d;       // 1 = master 2 was the last owner
  logic       mux_q, mux_d;
  logic       g1_q, g1_d, g2_q, g2_d;
  logic [2:0] sel_q, sel_d;
  logic       err_q, err_d;
  logic       tout_q, tout_d;

  // Returns {addr_error, slave_sel}.
  function automatic logic [3:0] decode(input logic [13:0] addr);
    case (addr[13:12])
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0010;
      2'b10:   return 4'b0100;
      default: return 4'b1000;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    last_d  = last_q;
    mux_d   = mux_q;
    tout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (m1_request && (!m2_request || ROUND_ROBIN == 0 || last_q)) begin
          state_d = M1_OWN;
          last_d  = 1'b0;
          hold_d  = '0;
          mux_d   = 1'b0;
        end else if (m2_request) begin
          state_d = M2_OWN;
          last_d  = 1'b1;
          hold_d  = '0;
          mux_d   = 1'b1;
        end
      end
      M1_OWN: begin
        if (!m1_request) begin
          state_d = TURN;
        end else if (hold_q == HOLD_LAST && m2_request) begin
          state_d = TURN;
          tout_d  = 1'b1;
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + 8'd1;
        end
      end
      M2_OWN: begin
        if (!m2_request) begin
          state_d = TURN;
        end else if (hold_q == HOLD_LAST && m1_request) begin
          state_d = TURN;
          tout_d  = 1'b1;
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + 8'd1;
        end
      end
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output next-state follows the state we are about to enter.
  always_comb begin
    g1_d  = (state_d == M1_OWN);
    g2_d  = (state_d == M2_OWN);
    sel_d = 3'b000;
    err_d = 1'b0;
    if (g1_d) begin
      {err_d, sel_d} = decode(m1_addr);
    end else if (g2_d) begin
      {err_d, sel_d} = decode(m2_addr);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      last_q  <= 1'b1;
      mux_q   <= 1'b0;
      g1_q    <= 1'b0;
      g2_q    <= 1'b0;
      sel_q   <= 3'b000;
      err_q   <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
      mux_q   <= mux_d;
      g1_q    <= g1_d;
      g2_q    <= g2_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
      tout_q  <= tout_d;
    end
  end

  assign m1_grant   = g1_q;
  assign m2_grant   = g2_q;
  assign bus_busy   = g1_q | g2_q;
  assign mux_sel    = mux_q;
  assign slave_sel  = sel_q;
  assign addr_error = err_q;
  assign timeout    = tout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: two instances (fixed priority, round robin) checked every cycle
// against a tenure-level reference model, plus directed scenarios and random traffic.
module tb_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        m1_request, m2_request;
  logic [13:0] m1_addr, m2_addr;

  logic       g1 [2];
  logic       g2 [2];
  logic       busy [2];
  logic       mux [2];
  logic [2:0] sel [2];
  logic       err [2];
  logic       tout [2];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: owner 0 = none, 1 = M1, 2 = M2; tenure counts owned cycles.
  int   mh [2] = '{6, 4};
  int   rr [2] = '{0, 1};
  int   owner [2];
  int   tenure [2];
  int   gap [2];
  int   last [2];
  bit   mux_m [2];
  bit   tout_m [2];
  logic [8:0] exp_v [2];

  bus_arbiter #(.ROUND_ROBIN(0), .MAX_HOLD(6)) dut0 (
    .clk(clk), .reset(reset),
    .m1_request(m1_request), .m2_request(m2_request),
    .m1_addr(m1_addr), .m2_addr(m2_addr),
    .m1_grant(g1[0]), .m2_grant(g2[0]), .bus_busy(busy[0]), .mux_sel(mux[0]),
    .slave_sel(sel[0]), .addr_error(err[0]), .timeout(tout[0])
  );

  bus_arbiter #(.ROUND_ROBIN(1), .MAX_HOLD(4)) dut1 (
    .clk(clk), .reset(reset),
    .m1_request(m1_request), .m2_request(m2_request),
    .m1_addr(m1_addr), .m2_addr(m2_addr),
    .m1_grant(g1[1]), .m2_grant(g2[1]), .bus_busy(busy[1]), .mux_sel(mux[1]),
    .slave_sel(sel[1]), .addr_error(err[1]), .timeout(tout[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] obs(input int k);
    return {g1[k], g2[k], busy[k], mux[k], sel[k], err[k], tout[k]};
  endfunction

  task automatic model_step();
    bit          r [3];
    logic [13:0] a [3];
    int          other;
    int          win;
    int          region;
    logic [2:0]  s;
    bit          e;
    r[0] = 1'b0; r[1] = m1_request; r[2] = m2_request;
    a[0] = '0;   a[1] = m1_addr;    a[2] = m2_addr;
    for (int k = 0; k < 2; k++) begin
      tout_m[k] = 1'b0;
      if (!reset) begin
        owner[k] = 0; gap[k] = 0; tenure[k] = 0; last[k] = 2; mux_m[k] = 1'b0;
      end else if (owner[k] != 0) begin
        other = 3 - owner[k];
        if (!r[owner[k]]) begin
          owner[k] = 0; gap[k] = 1;
        end else if (tenure[k] == mh[k] && r[other]) begin
          owner[k] = 0; gap[k] = 1; tout_m[k] = 1'b1;
        end else begin
          tenure[k]++;
        end
      end else if (gap[k] != 0) begin
        gap[k] = 0;
      end else begin
        if (r[1] && r[2]) win = (rr[k] != 0 && last[k] == 1) ? 2 : 1;
        else              win = r[1] ? 1 : (r[2] ? 2 : 0);
        if (win != 0) begin
          owner[k] = win; tenure[k] = 1; last[k] = win; mux_m[k] = (win == 2);
        end
      end
      s = 3'b000; e = 1'b0;
      if (owner[k] != 0) begin
        region = int'(a[owner[k]]) / 4096;
        if (region == 3) e = 1'b1;
        else             s = 3'(1 << region);
      end
      exp_v[k] = {owner[k] == 1, owner[k] == 2, owner[k] != 0, mux_m[k], s, e, tout_m[k]};
    end
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("dut%0d_outputs", k), 32'(obs(k)), 32'(exp_v[k]));
      check($sformatf("dut%0d_grant_excl", k), 32'(g1[k] & g2[k]), 32'd0);
    end
  end

  task automatic go_idle();
    @(negedge clk);
    m1_request = 1'b0; m2_request = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; m1_request = 1'b0; m2_request = 1'b0; m1_addr = '0; m2_addr = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'(obs(0)), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Single master
    m1_request = 1'b1; m1_addr = 14'd1001;
    @(posedge clk); #2;
    check("single_grant", 32'(g1[0]), 32'd1);
    check("single_sel", 32'(sel[0]), 32'b001);
    check("single_mux", 32'(mux[0]), 32'd0);
    repeat (4) @(negedge clk);
    m1_request = 1'b0;
    @(posedge clk); #2;
    check("single_release", 32'(busy[0]), 32'd0);
    go_idle();

    // Tie: dut0 favours M1, dut1 (M1 owned last) favours M2
    m1_request = 1'b1; m2_request = 1'b1; m1_addr = 14'd5097; m2_addr = 14'd9193;
    @(posedge clk); #2;
    check("tie_fixed_m1", 32'(g1[0]), 32'd1);
    check("tie_fixed_sel", 32'(sel[0]), 32'b010);
    check("tie_rr_m2", 32'(g2[1]), 32'd1);
    repeat (3) @(negedge clk);
    m1_request = 1'b0;
    repeat (3) @(posedge clk); #2;
    check("tie_then_m2", 32'(g2[0]), 32'd1);
    check("tie_then_mux", 32'(mux[0]), 32'd1);
    check("tie_then_sel", 32'(sel[0]), 32'b100);
    go_idle();

    // Continuous contention: model checks alternation and timeout pulses
    m1_request = 1'b1; m2_request = 1'b1; m1_addr = 14'd100; m2_addr = 14'd4200;
    repeat (30) @(negedge clk);
    go_idle();

    // Invalid address
    m2_request = 1'b1; m2_addr = 14'd12300;
    @(posedge clk); #2;
    check("inv_grant", 32'(g2[0]), 32'd1);
    check("inv_sel", 32'(sel[0]), 32'd0);
    check("inv_err", 32'(err[0]), 32'd1);
    @(negedge clk);
    m2_request = 1'b0;
    @(posedge clk); #2;
    check("inv_turn", 32'({g2[0], sel[0], err[0]}), 32'd0);
    go_idle();

    // Reset during an M1 tenure, then a tie on the round-robin instance
    m1_request = 1'b1; m1_addr = 14'd20;
    @(posedge clk); #2;
    repeat (3) @(negedge clk);
    reset = 1'b0; m2_request = 1'b1;
    @(posedge clk); #2;
    check("rst_mid_outputs", 32'(obs(1)), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #2;
    check("rst_rr_m1_wins", 32'(g1[1]), 32'd1);
    go_idle();

    // Owner releases exactly at the hold limit while M2 waits (dut1, limit 4)
    m1_request = 1'b1;
    @(posedge clk); #2;
    @(negedge clk);
    m2_request = 1'b1;
    repeat (3) @(negedge clk);
    m1_request = 1'b0;
    @(posedge clk); #2;
    check("edge_no_timeout", 32'(tout[1]), 32'd0);
    repeat (2) @(posedge clk); #2;
    check("edge_m2_grant", 32'(g2[1]), 32'd1);
    go_idle();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(7) == 0) m1_request = ~m1_request;
      if ($urandom_range(7) == 0) m2_request = ~m2_request;
      if ($urandom_range(3) == 0) m1_addr = 14'($urandom);
      if ($urandom_range(3) == 0) m2_addr = 14'($urandom);
      reset = ($urandom_range(199) != 0);
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
